axil_regfile: RTL

AXIL_REGFILE -- requirements
Module: axil_regfile

---
 rtl/axil_regfile.sv | 135 +++++++++++++
 1 files changed

// File: rtl/axil_regfile.sv
// AXI4-Lite slave register file: NUM_REGS byte-writable registers.
// Each register's contents are also exported in parallel on o_regs.
module axil_regfile #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 7,
    parameter int unsigned NUM_REGS           = 24
) (
    input  logic                                   S_AXI_ACLK,
    input  logic                                   S_AXI_ARESETN,
    input  logic                                   S_AXI_AWVALID,
    output logic                                   S_AXI_AWREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic [2:0]                             S_AXI_AWPROT,
    input  logic                                   S_AXI_WVALID,
    output logic                                   S_AXI_WREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    output logic                                   S_AXI_BVALID,
    input  logic                                   S_AXI_BREADY,
    output logic [1:0]                             S_AXI_BRESP,
    input  logic                                   S_AXI_ARVALID,
    output logic                                   S_AXI_ARREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic [2:0]                             S_AXI_ARPROT,
    output logic                                   S_AXI_RVALID,
    input  logic                                   S_AXI_RREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                             S_AXI_RRESP,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] o_regs
);

    localparam int unsigned DW       = C_S_AXI_DATA_WIDTH;
    localparam int unsigned SW       = DW / 8;
    localparam int unsigned ADDR_LSB = $clog2(SW);
    localparam int unsigned IDX_W    = C_S_AXI_ADDR_WIDTH - ADDR_LSB;
    localparam int unsigned IW       = $clog2(NUM_REGS * DW);

    logic              aw_full_q;
    logic              w_full_q;
    logic [IDX_W-1:0]  aw_idx_q;
    logic [DW-1:0]     w_data_q;
    logic [SW-1:0]     w_strb_q;

    logic              aw_hs_c;
    logic              w_hs_c;
    logic              ar_hs_c;
    logic              commit_c;
    logic              wr_hit_c;
    logic              rd_hit_c;
    logic              aw_full_n_c;
    logic              w_full_n_c;
    logic              rvalid_n_c;
    logic [IDX_W-1:0]  ar_idx_c;
    logic [IW-1:0]     wr_base_c;
    logic [IW-1:0]     rd_base_c;
    logic [DW-1:0]     wmask_c;
    logic [DW-1:0]     merged_c;

    // Protection bits and sub-word address bits carry no meaning here.
    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                         S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

    for (genvar b = 0; b < SW; b++) begin : g_mask
        assign wmask_c[8*b +: 8] = {8{w_strb_q[b]}};
    end

    // Handshakes, commit decision and next buffer/valid state.
    always_comb begin
        aw_hs_c     = S_AXI_AWVALID && S_AXI_AWREADY;
        w_hs_c      = S_AXI_WVALID && S_AXI_WREADY;
        ar_hs_c     = S_AXI_ARVALID && S_AXI_ARREADY;
        commit_c    = aw_full_q && w_full_q && (!S_AXI_BVALID || S_AXI_BREADY);
        ar_idx_c    = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
        wr_hit_c    = 32'(aw_idx_q) < NUM_REGS;
        rd_hit_c    = 32'(ar_idx_c) < NUM_REGS;
        wr_base_c   = IW'(32'(aw_idx_q) * DW);
        rd_base_c   = IW'(32'(ar_idx_c) * DW);
        merged_c    = (o_regs[wr_base_c +: DW] & ~wmask_c) | (w_data_q & wmask_c);
        aw_full_n_c = commit_c ? 1'b0 : (aw_full_q || aw_hs_c);
        w_full_n_c  = commit_c ? 1'b0 : (w_full_q || w_hs_c);
        rvalid_n_c  = ar_hs_c || (S_AXI_RVALID && !S_AXI_RREADY);
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            aw_full_q     <= 1'b0;
            w_full_q      <= 1'b0;
            aw_idx_q      <= '0;
            w_data_q      <= '0;
            w_strb_q      <= '0;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= 2'b00;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
            S_AXI_RRESP   <= 2'b00;
            o_regs        <= '0;
        end else begin
            aw_full_q     <= aw_full_n_c;
            w_full_q      <= w_full_n_c;
            S_AXI_AWREADY <= !aw_full_n_c;
            S_AXI_WREADY  <= !w_full_n_c;
            S_AXI_RVALID  <= rvalid_n_c;
            S_AXI_ARREADY <= !rvalid_n_c;

            if (aw_hs_c) begin
                aw_idx_q <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
            end
            if (w_hs_c) begin
                w_data_q <= S_AXI_WDATA;
                w_strb_q <= S_AXI_WSTRB;
            end

            // A commit on a BREADY edge re-arms BVALID for the new response.
            if (commit_c) begin
                S_AXI_BVALID <= 1'b1;
                S_AXI_BRESP  <= wr_hit_c ? 2'b00 : 2'b10;
                if (wr_hit_c) begin
                    o_regs[wr_base_c +: DW] <= merged_c;
                end
            end else if (S_AXI_BREADY) begin
                S_AXI_BVALID <= 1'b0;
            end

            if (ar_hs_c) begin
                S_AXI_RDATA <= rd_hit_c ? o_regs[rd_base_c +: DW] : '0;
                S_AXI_RRESP <= rd_hit_c ? 2'b00 : 2'b10;
            end
        end
    end

endmodule
